anita3_readout_scheduler: RTL
=============================

// Module: anita3_readout_scheduler
// PURPOSE
//  Sequences readout of held LAB buffers. Sits between the trigger buffer manager and the LAB digitizer/readout engine.
//  Captures each digitize event (buffer index + trigger source) into a trigger-ordered queue.
//  Issues one readout request at a time to the digitizer and waits for completion.
//  Then pulses clear back to the buffer manager, freeing that buffer.
// PARAMETERS
//  NUM_HOLD        4      number of LAB hold buffers; queue depth equals NUM_HOLD (fixed 4, 2-bit index)
//  TIMEOUT_CYCLES  65535  max clk250_i cycles from request issue to read_done_i before forced clear (16-bit)
// PORTS
//  clk250_i            in   1  250 MHz system clock; single clock domain
//  rst_i               in   1  reset, synchronous, active-high
//  digitize_i          in   1  digitize flag from buffer manager; level, held high for the trigger holdoff period
//  digitize_buffer_i   in   2  buffer index to digitize; valid on digitize_i rising edge
//  digitize_source_i   in   4  trigger source bits; valid on digitize_i rising edge
//  read_req_o          out  1  readout request to digitizer
//  read_buffer_o       out  2  buffer index for current readout
//  read_source_o       out  4  trigger source for current readout
//  read_ack_i          in   1  digitizer accepted request
//  read_done_i         in   1  digitizer finished reading buffer
//  clear_o             out  1  one-cycle pulse: free buffer in buffer manager
//  clear_buffer_o      out  2  buffer index to free; valid with clear_o
//  pending_o           out  3  queue occupancy 0..4
//  busy_o              out  1  FSM not in IDLE
//  overflow_o          out  1  sticky: event dropped because queue full
//  timeout_o           out  1  sticky: readout timed out, buffer force-cleared
// BEHAVIOUR
//  Reset values: all outputs 0, queue empty, FSM=IDLE, edge-detect register 0.
//  Sticky flags clear only on rst_i.
//  Event detect: evt = digitize_i & ~digitize_q, with digitize_q registered every cycle.
//  A level held high yields exactly one event.
//  Queue:
//   - 4-entry FIFO of {source,buffer}, 2-bit read/write pointers wrapping 3->0.
//   - evt pushes; pending_o increments the next cycle.
//   - Push with pending==4: entry dropped, pointers unchanged, overflow_o set.
//   - Push and pop in the same cycle: both occur, count unchanged. A full queue with a simultaneous pop accepts the push.
//  FSM: IDLE -> REQ -> READ -> CLEAR -> IDLE
//   - IDLE: if pending>0, pop head into read_buffer_o/read_source_o, zero timer, go REQ.
//     Outputs hold their last value while idle.
//   - REQ: read_req_o=1. On a cycle with read_ack_i=1, go READ; read_req_o is 0 from the next cycle.
//   - READ: on read_done_i=1, go CLEAR.
//   - CLEAR: clear_o=1 and clear_buffer_o=read_buffer_o for exactly one cycle, then IDLE.
//   - Timer: 16-bit, counts every cycle in REQ and READ.
//     If it reaches TIMEOUT_CYCLES-1 without the exit condition: go CLEAR and set timeout_o.
//     An exit condition in that same cycle wins, with no timeout.
//   - read_ack_i outside REQ and read_done_i outside READ are ignored.
//     Ack and done high together in REQ: only ack counts; done must be re-asserted in READ.
//  Latency: evt sampled at cycle N with FSM idle and queue empty gives pending_o=1 at N+1 and read_req_o=1 at N+2.
//  The minimum spacing between consecutive clears is 4 cycles (ack and done each arriving on their first possible cycle).
//  Ordering: clears are issued strictly in trigger order.
//  Reset mid-operation: everything returns to reset state immediately.
//   - No clear is issued for in-flight or queued buffers.
//   - The buffer manager shares rst_i and frees them itself.
// TESTING
//  1. Single event: digitize_i high 25 cycles, buf=2, src=4'b0101.
//     Expect one read_req_o with read_buffer_o=2/read_source_o=5; ack at +3, done at +10.
//     Then exactly one clear_o with clear_buffer_o=2; pending_o back to 0.
//  2. Four events (bufs 0,1,2,3), digitizer stalled with no ack.
//     Expect pending_o=3 after the first pop; no overflow_o.
//     Release: clears issued in order 0,1,2,3.
//  3. Fifth event while pending_o=4 and no pop: overflow_o=1, entry discarded, later clears still only 0..3.
//     Repeat with the push coinciding with an IDLE pop: accepted, no overflow.
//  4. Timeout with TIMEOUT_CYCLES=16: ack given, done withheld.
//     clear_o asserts at cycle 16 after REQ entry and timeout_o=1; the next queued entry proceeds normally.
//  5. Ack and done both high on the same REQ cycle: FSM goes to READ only; clear_o only after a later done pulse.
//  6. rst_i asserted mid-READ with 2 queued: all outputs 0 next cycle, no clear_o.
//     A new event after reset is serviced normally.

Source files
------------

// File: rtl/anita3_readout_scheduler_if.sv
// Bundles the buffer-manager, digitizer and status signals of the readout scheduler.
// The scheduler connects through the slave modport; the environment driving it uses master.
interface anita3_readout_scheduler_if;
    logic       digitize_i;
    logic [1:0] digitize_buffer_i;
    logic [3:0] digitize_source_i;
    logic       read_req_o;
    logic [1:0] read_buffer_o;
    logic [3:0] read_source_o;
    logic       read_ack_i;
    logic       read_done_i;
    logic       clear_o;
    logic [1:0] clear_buffer_o;
    logic [2:0] pending_o;
    logic       busy_o;
    logic       overflow_o;
    logic       timeout_o;

    modport slave (
        input  digitize_i, digitize_buffer_i, digitize_source_i,
        input  read_ack_i, read_done_i,
        output read_req_o, read_buffer_o, read_source_o,
        output clear_o, clear_buffer_o, pending_o, busy_o, overflow_o, timeout_o
    );

    modport master (
        output digitize_i, digitize_buffer_i, digitize_source_i,
        output read_ack_i, read_done_i,
        input  read_req_o, read_buffer_o, read_source_o,
        input  clear_o, clear_buffer_o, pending_o, busy_o, overflow_o, timeout_o
    );
endinterface

// File: rtl/anita3_readout_scheduler.sv
// Queues LAB digitize events in trigger order, runs one digitizer readout at a time
// and frees each buffer back to the buffer manager with a one-cycle clear.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no readout in flight; pops the queue head when one is pending
// S_REQ   | read_req_o high, waiting for read_ack_i
// S_READ  | digitizer reading the buffer, waiting for read_done_i
// S_CLEAR | one-cycle clear_o for read_buffer_o, then back to idle
module anita3_readout_scheduler #(
    parameter int unsigned NUM_HOLD       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk250_i,
    input  logic                        rst_i,
    anita3_readout_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_READ  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    // Down-counter loaded on pop; reaching zero matches an up-count hitting TIMEOUT_CYCLES-1.
    localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        digitize_q;
    logic [5:0]  fifo_q [NUM_HOLD];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  count_q;
    logic [1:0]  read_buffer_q;
    logic [3:0]  read_source_q;
    logic [15:0] timer_q, timer_d;
    logic        overflow_q, timeout_q;

    logic        evt, pop, push, full, timeout_set;

    assign evt  = bus.digitize_i & ~digitize_q;
    assign full = (count_q == 3'(NUM_HOLD));
    assign pop  = (state_q == S_IDLE) && (count_q != 3'd0);
    // A full queue still takes the push when the head leaves in the same cycle.
    assign push = evt && (!full || pop);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_REQ;
                    timer_d = TIMER_LOAD;
                end
            end
            S_REQ: begin
                timer_d = timer_q - 16'd1;
                if (bus.read_ack_i) begin
                    state_d = S_READ;
                end else if (timer_q == 16'd0) begin
                    state_d     = S_CLEAR;
                    timeout_set = 1'b1;
                end
            end
            S_READ: begin
                timer_d = timer_q - 16'd1;
                if (bus.read_done_i) begin
                    state_d = S_CLEAR;
                end else if (timer_q == 16'd0) begin
                    state_d     = S_CLEAR;
                    timeout_set = 1'b1;
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk250_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            digitize_q    <= 1'b0;
            wr_ptr_q      <= 2'd0;
            rd_ptr_q      <= 2'd0;
            count_q       <= 3'd0;
            read_buffer_q <= 2'd0;
            read_source_q <= 4'd0;
            timer_q       <= 16'd0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            digitize_q <= bus.digitize_i;

            if (push) begin
                fifo_q[wr_ptr_q] <= {bus.digitize_source_i, bus.digitize_buffer_i};
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                {read_source_q, read_buffer_q} <= fifo_q[rd_ptr_q];
                rd_ptr_q                       <= rd_ptr_q + 2'd1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase

            if (evt && !push) begin
                overflow_q <= 1'b1;
            end
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.read_req_o     = (state_q == S_REQ);
    assign bus.read_buffer_o  = read_buffer_q;
    assign bus.read_source_o  = read_source_q;
    assign bus.clear_o        = (state_q == S_CLEAR);
    assign bus.clear_buffer_o = (state_q == S_CLEAR) ? read_buffer_q : 2'd0;
    assign bus.pending_o      = count_q;
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.overflow_o     = overflow_q;
    assign bus.timeout_o      = timeout_q;

endmodule
